// File: rtl/rca_sweep_checker.sv
// Sweeps a deterministic sequence of operand pairs into an external N-bit adder
// and checks each registered sum, reporting mismatch count and first failing index.
module rca_sweep_checker #(
  parameter int unsigned N         = 5,
  parameter int unsigned A_INIT    = 4,
  parameter int unsigned B_INIT    = 20,
  parameter logic [2:0]  A_STEP    = 3'd2,
  parameter int unsigned B_STEP    = 3,
  parameter int unsigned VEC_COUNT = 50
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [N-1:0]  a,
  output logic [N-1:0]  b,
  input  logic [N:0]    dut_out,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [15:0]   first_fail_idx
);

  localparam int unsigned CW = 16;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [N-1:0]  A0      = N'(A_INIT);
  localparam logic [N-1:0]  B0      = N'(B_INIT);
  localparam logic [CW-1:0] K_LAST  = CW'(VEC_COUNT - 1);
  localparam logic [CW-1:0] NO_FAIL = 16'hFFFF;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [CW-1:0] err_q, err_d, ffi_q, ffi_d;
  logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [N:0]    expected_c;
  logic          mismatch_c;

  assign expected_c = (N+1)'(a_q) + (N+1)'(b_q);
  assign mismatch_c = (dut_out != expected_c);

  // State, operand and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= A0;
      b_q     <= B0;
      err_q   <= '0;
      ffi_q   <= NO_FAIL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state: sweep sequencing and per-vector check
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    ffi_d   = ffi_q;

    case (state_q)
      RUN: begin
        if (mismatch_c) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (err_q == '0)       ffi_d = k_q;
        end
        if (k_q == K_LAST) begin
          state_d = DONE;
          a_d     = A0;
          b_d     = B0;
        end else begin
          k_d = k_q + 16'd1;
          a_d = a_q + N'(A_STEP);
          // b advances once per vector pair, after odd k
          if (k_q[0]) b_d = b_q + N'(B_STEP);
        end
      end
      default: begin
        a_d = A0;
        b_d = B0;
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          err_d   = '0;
          ffi_d   = NO_FAIL;
        end
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_d == '0);
  end

  assign a              = a_q;
  assign b              = b_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_rca_sweep_checker.sv
// Bench for rca_sweep_checker: behavioural adder with injectable faults,
// table of sweep results plus reset/restart sequences.
module tb_rca_sweep_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  a, b;
  logic [5:0]  dut_out;
  logic        busy, done, pass;
  logic [15:0] err_count, first_fail_idx;

  int checks = 0;
  int errors = 0;
  int fault  = 0;

  always #5 clk = ~clk;

  rca_sweep_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_idx(first_fail_idx)
  );

  // Adder under check: 0 correct, 1 bit0 stuck-0, 2 bit5 stuck-0, 3 bit0 inverted
  always_comb begin
    dut_out = {1'b0, a} + {1'b0, b};
    case (fault)
      1: dut_out[0] = 1'b0;
      2: dut_out[5] = 1'b0;
      3: dut_out[0] = ~dut_out[0];
      default: ;
    endcase
  end

  typedef struct {
    int          flt;
    logic [15:0] exp_err;
    logic [15:0] exp_ffi;
    logic        exp_pass;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_a", 32'(a), 32'd4);
    chk("rst_b", 32'(b), 32'd20);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_ffi", 32'(first_fail_idx), 32'hFFFF);
  endtask

  // Pulse start, walk the sweep checking operands, optional start noise during RUN
  task automatic run_sweep(input bit noise, input int stop_at, output int busy_cycles);
    int cnt;
    logic [4:0] ea, eb;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200 && cnt != stop_at) begin
      ea = 5'(4 + 2 * cnt);
      eb = 5'(20 + 3 * (cnt / 2));
      chk($sformatf("a_k%0d", cnt), 32'(a), 32'(ea));
      chk($sformatf("b_k%0d", cnt), 32'(b), 32'(eb));
      cnt++;
      start = noise && ((cnt % 7) == 3);
      @(negedge clk);
    end
    start = 1'b0;
    busy_cycles = cnt;
  endtask

  initial begin
    int bc;
    vecs[0] = '{flt: 1, exp_err: 16'd24, exp_ffi: 16'd2,     exp_pass: 1'b0};
    vecs[1] = '{flt: 2, exp_err: 16'd24, exp_ffi: 16'd3,     exp_pass: 1'b0};
    vecs[2] = '{flt: 3, exp_err: 16'd50, exp_ffi: 16'd0,     exp_pass: 1'b0};
    vecs[3] = '{flt: 0, exp_err: 16'd0,  exp_ffi: 16'hFFFF,  exp_pass: 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    #12;
    chk_reset_state();
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold_busy", 32'(busy), 32'd0);
    chk("idle_hold_done", 32'(done), 32'd0);

    // Correct adder, clean start
    fault = 0;
    run_sweep(1'b0, -1, bc);
    chk("busy_len", 32'(bc), 32'd50);
    chk("done", 32'(done), 32'd1);
    chk("pass", 32'(pass), 32'd1);
    chk("err", 32'(err_count), 32'd0);
    chk("ffi", 32'(first_fail_idx), 32'hFFFF);
    repeat (3) @(negedge clk);
    chk("done_hold", 32'(done), 32'd1);
    chk("done_a", 32'(a), 32'd4);
    chk("done_b", 32'(b), 32'd20);

    // Table of faults; each sweep restarts from DONE of the previous one
    for (int i = 0; i < 4; i++) begin
      fault = vecs[i].flt;
      run_sweep(1'b0, -1, bc);
      chk($sformatf("t%0d_len", i), 32'(bc), 32'd50);
      chk($sformatf("t%0d_done", i), 32'(done), 32'd1);
      chk($sformatf("t%0d_err", i), 32'(err_count), 32'(vecs[i].exp_err));
      chk($sformatf("t%0d_ffi", i), 32'(first_fail_idx), 32'(vecs[i].exp_ffi));
      chk($sformatf("t%0d_pass", i), 32'(pass), 32'(vecs[i].exp_pass));
    end

    // Start pulses during RUN must not stretch or restart the sweep
    fault = 1;
    run_sweep(1'b1, -1, bc);
    chk("noise_len", 32'(bc), 32'd50);
    chk("noise_err", 32'(err_count), 32'd24);
    chk("noise_ffi", 32'(first_fail_idx), 32'd2);

    // Reset mid-sweep at k=10 after some mismatches have accumulated
    run_sweep(1'b0, 10, bc);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_err", 32'(err_count), 32'd4);
    rst_n = 1'b0;
    #1;
    chk_reset_state();
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    fault = 0;
    run_sweep(1'b0, -1, bc);
    chk("post_rst_len", 32'(bc), 32'd50);
    chk("post_rst_pass", 32'(pass), 32'd1);
    chk("post_rst_ffi", 32'(first_fail_idx), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_sweep_checker.md
RCA_SWEEP_CHECKER -- requirements
Module: rca_sweep_checker

Interface
REQ-001 Parameter N, default 5: operand width of the adder under check.
REQ-002 Parameter A_INIT, default 4: first operand a value.
REQ-003 Parameter B_INIT, default 20: first operand b value.
REQ-004 Parameter A_STEP, default 3'd2: a increment per vector.
REQ-005 Parameter B_STEP, default 3: b increment per vector pair.
REQ-006 Parameter VEC_COUNT, default 50: vectors per sweep, range 1..65535.
REQ-007 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-008 clk  input  1  rising-edge clock.
REQ-009 rst_n  input  1  asynchronous active-low reset.
REQ-010 start  input  1  sweep request, sampled on the rising edge of clk.
REQ-011 a  output  N  operand a to the adder, registered.
REQ-012 b  output  N  operand b to the adder, registered.
REQ-013 dut_out  input  N+1  adder sum, combinational from a and b.
REQ-014 busy  output  1  sweep in progress.
REQ-015 done  output  1  sweep complete; results valid.
REQ-016 pass  output  1  done and zero mismatches.
REQ-017 err_count  output  16  mismatch count.
REQ-018 first_fail_idx  output  16  index of the first mismatching vector.

Function
REQ-019 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-020 In IDLE, start=1 SHALL cause a transition to RUN and clear err_count.
REQ-021 In IDLE, start=1 SHALL set first_fail_idx to 16'hFFFF and the vector index k to 0.
REQ-022 In RUN, the block SHALL drive vector k with a = (A_INIT + k*A_STEP) mod 2^N.
REQ-023 In RUN, vector k SHALL drive b = (B_INIT + floor(k/2)*B_STEP) mod 2^N.
REQ-024 Vector k SHALL be held for exactly one clock cycle.
REQ-025 At the edge ending cycle k, the block SHALL compare dut_out with expected = a + b, computed N+1 bits wide with carry.
REQ-026 On a mismatch, err_count SHALL increment, saturating at 16'hFFFF.
REQ-027 On the first mismatch only, first_fail_idx SHALL be set to k.
REQ-028 After vector VEC_COUNT-1 is checked, the FSM SHALL enter DONE; busy is high for exactly VEC_COUNT cycles.
REQ-029 In DONE, done SHALL be 1 and pass SHALL equal (err_count==0).
REQ-030 err_count and first_fail_idx SHALL hold their values in DONE.
REQ-031 In DONE, start=1 SHALL restart the sweep exactly as from IDLE.
REQ-032 start SHALL be ignored while in RUN.
REQ-033 Operand wrap-around SHALL be silent modulo 2^N and SHALL NOT be flagged.
REQ-034 In IDLE and DONE, a SHALL hold A_INIT and b SHALL hold B_INIT.
REQ-035 busy, done and pass SHALL be driven from state registers only, with no combinational path from dut_out.

Reset
REQ-036 On rst_n=0 the block SHALL immediately enter IDLE, in any state including mid-RUN.
REQ-037 Reset SHALL set a=A_INIT, b=B_INIT, busy=0, done=0, pass=0, err_count=0, first_fail_idx=16'hFFFF and k=0.
REQ-038 After rst_n deasserts, the block SHALL stay in IDLE until start is seen.

Verification
REQ-039 Reset check: assert rst_n=0 -> a=4, b=20, busy=0, done=0, pass=0, err_count=0, first_fail_idx=16'hFFFF.
REQ-040 Correct adder model, defaults, 1-cycle start -> a sequence 4,6,8,..,30,0,2 (wraps at k=14).
REQ-041 Same run -> b sequence 20,20,23,23,26,26,29,29,0 (k=8); busy high 50 cycles; done=1, pass=1, err_count=0, first_fail_idx=16'hFFFF.
REQ-042 dut_out[0] stuck at 0 -> first_fail_idx=2 (8+23=31); err_count=24; pass=0.
REQ-043 dut_out[5] stuck at 0 -> first_fail_idx=3 (10+23=33); pass=0.
REQ-044 Start pulses during RUN -> sweep length unchanged.
REQ-045 rst_n=0 at k=10 -> IDLE with all reset values; a following start runs a full 50-vector sweep.
REQ-046 start in DONE after a failing sweep -> counters cleared; with a correct model the result is pass=1.
